imem_fetch_ctrl: RTL and testbench



---
 rtl/imem_fetch_ctrl.sv | 130 +++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer for a byte-wide synchronous RAM: four byte reads per
// 32-bit word (big-endian), with the program loader sharing the single memory port.
module imem_fetch_ctrl #(
    parameter int AW        = 8,
    parameter int MEM_BYTES = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_addr,
    output logic          fetch_ready,
    output logic          fetch_valid,
    output logic [31:0]   fetch_instr,
    output logic          fetch_err,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [7:0]    load_data,
    output logic          load_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

    state_t        state_q;
    logic [2:0]    cnt_q;
    logic [AW-1:0] base_q;
    logic [31:0]   asm_q;
    logic [31:0]   instr_q;
    logic          valid_q;
    logic          err_q;

    logic          addr_ok;
    logic          accept;

    assign addr_ok     = (fetch_addr[1:0] == 2'b00) && (fetch_addr <= MAX_ADDR);
    assign fetch_ready = (state_q == IDLE) && !load_we && !flush;
    assign accept      = fetch_req && fetch_ready;

    // The loader only gets the port between fetches, so it never disturbs one in flight.
    assign load_ack  = (state_q == IDLE) && load_we;
    assign mem_we    = load_ack;
    assign mem_wdata = load_ack ? load_data : 8'h00;

    always_comb begin
        mem_addr = '0;
        if (load_ack) begin
            mem_addr = load_addr;
        end else if (state_q == FETCH && cnt_q < 3'd4) begin
            mem_addr = base_q + AW'(cnt_q);
        end
    end

    // A flush in the response cycle hides that cycle's pulse.
    assign fetch_valid = valid_q && !flush;
    assign fetch_err   = err_q;
    assign fetch_instr = instr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            asm_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (flush && state_q != IDLE) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (accept) begin
                        if (addr_ok) begin
                            base_q  <= fetch_addr[AW-1:0];
                            cnt_q   <= '0;
                            state_q <= FETCH;
                        end else begin
                            instr_q <= '0;
                            valid_q <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end
                    end
                end
                FETCH: begin
                    // Read data lags the address by one cycle, so byte k-1 arrives at cnt=k.
                    if (cnt_q != 3'd0) begin
                        asm_q <= {asm_q[23:0], mem_rdata};
                    end
                    if (cnt_q == 3'd4) begin
                        instr_q <= {asm_q[23:0], mem_rdata};
                        valid_q <= 1'b1;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                RESP: begin
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a vector table of fetches against a byte RAM
// model, plus hand-written sequences for loader priority, flush and reset aborts.
module tb_imem_fetch_ctrl;

    localparam int AW = 8;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          fetch_ready;
    logic          fetch_valid;
    logic [31:0]   fetch_instr;
    logic          fetch_err;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [7:0]    load_data;
    logic          load_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    logic [7:0]    ram [0:255];

    int n_cmp;
    int n_bad;

    imem_fetch_ctrl #(.AW(AW), .MEM_BYTES(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr),
        .fetch_err  (fetch_err),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ack   (load_ack),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read byte RAM
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        check("load_ack", {31'd0, load_ack}, 32'd1);
        @(posedge clk);
        #1 load_we = 1'b0;
    endtask

    // Returns at posedge+1 just after the accept edge.
    task automatic start_fetch(input logic [31:0] a);
        int w;
        fetch_req  = 1'b1;
        fetch_addr = a;
        w = 0;
        @(negedge clk);
        while (!fetch_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_accept", {31'd0, fetch_ready}, 32'd1);
        if (fetch_err === 1'b0) check("idle_mem_addr", {24'd0, mem_addr}, 32'd0);
        @(posedge clk);
        #1 fetch_req = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp_instr,
                            input logic exp_err, input int exp_lat);
        int  lat;
        bit  seen;
        start_fetch(a);
        lat  = 0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fetch_valid) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1 lat++;
        end
        check("valid_seen", {31'd0, seen}, 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("fetch_instr", fetch_instr, exp_instr);
        check("fetch_err", {31'd0, fetch_err}, {31'd0, exp_err});
        if (exp_err) begin
            check("err_no_mem_addr", {24'd0, mem_addr}, 32'd0);
            check("err_no_mem_we", {31'd0, mem_we}, 32'd0);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        check("valid_one_cycle", {31'd0, fetch_valid}, 32'd0);
        check("err_cleared", {31'd0, fetch_err}, 32'd0);
        check("instr_held", fetch_instr, exp_instr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  lat;
        bit  seen;
        int  stray;

        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 5};
        vecs[1] = '{32'h0000_0002, 32'h0000_0000, 1'b1, 0};
        vecs[2] = '{32'h0000_00FC, 32'h0102_0304, 1'b0, 5};
        vecs[3] = '{32'h0000_0100, 32'h0000_0000, 1'b1, 0};
        vecs[4] = '{32'h0000_0014, 32'h1122_3344, 1'b0, 5};
        vecs[5] = '{32'h0000_0000, 32'hCAFE_BABE, 1'b0, 5};
        vecs[6] = '{32'h0000_00FD, 32'h0000_0000, 1'b1, 0};
        vecs[7] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 0};
        vecs[8] = '{32'h8000_0010, 32'h0000_0000, 1'b1, 0};

        reset      = 1'b1;
        flush      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        load_we    = 1'b0;
        load_addr  = '0;
        load_data  = '0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        check("rst_fetch_instr", fetch_instr, 32'd0);
        check("rst_fetch_ready", {31'd0, fetch_ready}, 32'd1);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_load_ack", {31'd0, load_ack}, 32'd0);
        @(posedge clk);
        #1;

        load_byte(8'h10, 8'hDE); load_byte(8'h11, 8'hAD);
        load_byte(8'h12, 8'hBE); load_byte(8'h13, 8'hEF);
        load_byte(8'h14, 8'h11); load_byte(8'h15, 8'h22);
        load_byte(8'h16, 8'h33); load_byte(8'h17, 8'h44);
        load_byte(8'hFC, 8'h01); load_byte(8'hFD, 8'h02);
        load_byte(8'hFE, 8'h03); load_byte(8'hFF, 8'h04);
        load_byte(8'h00, 8'hCA); load_byte(8'h01, 8'hFE);
        load_byte(8'h02, 8'hBA); load_byte(8'h03, 8'hBE);

        for (int i = 0; i < 9; i++) begin
            $display("vector %0d: addr %h", i, vecs[i].addr);
            do_fetch(vecs[i].addr, vecs[i].instr, vecs[i].err, vecs[i].lat);
        end

        // Loader and fetch together in IDLE: loader wins this cycle.
        load_we    = 1'b1;
        load_addr  = 8'h20;
        load_data  = 8'h5A;
        fetch_req  = 1'b1;
        fetch_addr = 32'h10;
        @(negedge clk);
        check("prio_load_ack", {31'd0, load_ack}, 32'd1);
        check("prio_fetch_ready", {31'd0, fetch_ready}, 32'd0);
        check("prio_mem_we", {31'd0, mem_we}, 32'd1);
        check("prio_mem_addr", {24'd0, mem_addr}, 32'h20);
        @(posedge clk);
        #1 load_we = 1'b0;
        @(negedge clk);
        check("prio_ready_next", {31'd0, fetch_ready}, 32'd1);
        @(posedge clk);
        #1 fetch_req = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        load_we   = 1'b1;
        load_addr = 8'h21;
        load_data = 8'h6B;
        lat  = 2;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fetch_valid) begin
                seen = 1;
                break;
            end
            check("busy_load_ack", {31'd0, load_ack}, 32'd0);
            check("busy_mem_we", {31'd0, mem_we}, 32'd0);
            @(posedge clk);
            #1 lat++;
        end
        check("busy_valid_seen", {31'd0, seen}, 32'd1);
        check("busy_latency", 32'(lat), 32'd5);
        check("busy_instr", fetch_instr, 32'hDEAD_BEEF);
        check("resp_load_ack", {31'd0, load_ack}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("idle_load_ack", {31'd0, load_ack}, 32'd1);
        check("idle_load_addr", {24'd0, mem_addr}, 32'h21);
        @(posedge clk);
        #1 load_we = 1'b0;
        load_byte(8'h22, 8'h77);
        load_byte(8'h23, 8'h88);
        do_fetch(32'h20, 32'h5A6B_7788, 1'b0, 5);

        // Flush while FETCH is at cnt=2.
        start_fetch(32'h10);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_ready_low", {31'd0, fetch_ready}, 32'd0);
        check("flush_valid_low", {31'd0, fetch_valid}, 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_to_idle", {31'd0, fetch_ready}, 32'd1);
        check("flush_no_valid", {31'd0, fetch_valid}, 32'd0);
        @(posedge clk);
        #1;
        do_fetch(32'h14, 32'h1122_3344, 1'b0, 5);

        // Reset at cnt=3 must leave no trace of the aborted fetch.
        start_fetch(32'h10);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", {31'd0, fetch_valid}, 32'd0);
        check("mid_rst_instr", fetch_instr, 32'd0);
        check("mid_rst_ready", {31'd0, fetch_ready}, 32'd1);
        check("mid_rst_err", {31'd0, fetch_err}, 32'd0);
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (fetch_valid) stray++;
        end
        check("mid_rst_no_stale", 32'(stray), 32'd0);
        @(posedge clk);
        #1;

        // Flush does not block loader writes in IDLE.
        flush = 1'b1;
        load_byte(8'h30, 8'h99);
        flush = 1'b0;

        // Flush in the error response cycle suppresses the pulse.
        start_fetch(32'hFD);
        flush = 1'b1;
        @(negedge clk);
        check("flush_resp_valid", {31'd0, fetch_valid}, 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_resp_after", {31'd0, fetch_valid}, 32'd0);
        check("flush_resp_ready", {31'd0, fetch_ready}, 32'd1);
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
